// File: rtl/uart_tx_buffer.sv
// UART transmit path: byte FIFO feeding an 8N1 serialiser.
// Back-to-back frames run without an idle gap while bytes are queued.
module uart_tx_buffer #(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int DEPTH_LOG2       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            wdata,
  input  logic                  we,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  busy,
  output logic                  byte_done,
  output logic                  overflow,
  output logic                  txd
);

  localparam int BIT_CYCLES = 2 * CLK_PER_HALF_BIT;
  localparam int TW         = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int CW         = DEPTH_LOG2 + 1;

  localparam logic [TW-1:0] TC       = TW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                r_state;
  state_t                w_state_n;
  logic [TW-1:0]         r_timer;
  logic [TW-1:0]         w_timer_n;
  logic [2:0]            r_idx;
  logic [2:0]            w_idx_n;
  logic [7:0]            r_shift;
  logic [7:0]            w_shift_n;
  logic                  r_txd;
  logic                  w_txd_n;
  logic                  r_done;
  logic                  w_done_n;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_n;
  logic                  r_full;
  logic                  r_ovf;

  logic                  w_tc;
  logic                  w_have;
  logic                  w_pop;
  logic                  w_accept;
  logic [7:0]            w_head;

  assign w_tc     = (r_timer == TC);
  assign w_have   = (r_count != '0);
  assign w_accept = we & ~r_full;
  assign w_head   = r_mem[r_rptr];

  // Serialiser next state; pops only ever see the registered count
  always_comb begin
    w_state_n = r_state;
    w_timer_n = r_timer + TW'(1);
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_pop     = 1'b0;
    w_done_n  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_timer_n = '0;
        if (w_have) begin
          w_pop     = 1'b1;
          w_shift_n = w_head;
          w_state_n = S_START;
        end
      end
      S_START: begin
        if (w_tc) begin
          w_timer_n = '0;
          w_idx_n   = '0;
          w_state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tc) begin
          w_timer_n = '0;
          w_shift_n = {1'b0, r_shift[7:1]};
          w_idx_n   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_n = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (w_tc) begin
          w_timer_n = '0;
          w_done_n  = 1'b1;
          if (w_have) begin
            w_pop     = 1'b1;
            w_shift_n = w_head;
            w_state_n = S_START;
          end else begin
            w_state_n = S_IDLE;
          end
        end
      end
      default: begin
        w_timer_n = '0;
        w_state_n = S_IDLE;
      end
    endcase
  end

  // Line level is registered from the next state, so txd is glitch-free
  always_comb begin
    w_txd_n = 1'b1;
    unique case (w_state_n)
      S_START: w_txd_n = 1'b0;
      S_DATA:  w_txd_n = w_shift_n[0];
      default: w_txd_n = 1'b1;
    endcase
  end

  always_comb begin
    w_count_n = r_count;
    unique case ({w_accept, w_pop})
      2'b10:   w_count_n = r_count + CW'(1);
      2'b01:   w_count_n = r_count - CW'(1);
      default: w_count_n = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
      r_done  <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_timer <= w_timer_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_txd   <= w_txd_n;
      r_done  <= w_done_n;
      r_count <= w_count_n;
      r_full  <= (w_count_n == FULL_CNT);
      if (w_accept) begin
        r_wptr <= r_wptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + DEPTH_LOG2'(1);
      end
      if (we && r_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  assign full      = r_full;
  assign count     = r_count;
  assign busy      = w_have | (r_state != S_IDLE);
  assign byte_done = r_done;
  assign overflow  = r_ovf;
  assign txd       = r_txd;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: directed scenarios plus random traffic
// against a frame-timeline reference model.
module tb_uart_tx_buffer;

  localparam int HB    = 4;
  localparam int BC    = 2 * HB;
  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;
  localparam int FRAME = 10 * BC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [7:0]  wdata = '0;
  logic        full;
  logic [DL:0] count;
  logic        busy;
  logic        byte_done;
  logic        overflow;
  logic        txd;

  always #5 clk = ~clk;

  uart_tx_buffer #(
    .CLK_PER_HALF_BIT(HB),
    .DEPTH_LOG2(DL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wdata(wdata),
    .we(we),
    .full(full),
    .count(count),
    .busy(busy),
    .byte_done(byte_done),
    .overflow(overflow),
    .txd(txd)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  bit         m_in;
  int         m_t;
  logic [7:0] m_byte;
  bit         m_done;
  bit         m_ovf;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Line level from the position inside the current frame
  function automatic logic m_txd();
    int slot;
    if (!m_in) return 1'b1;
    slot = m_t / BC;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_byte[slot-1];
    return 1'b1;
  endfunction

  task automatic model_edge(input bit r, input bit w, input logic [7:0] d);
    int sz0;
    if (r) begin
      mq.delete();
      m_in = 0;
      m_t = 0;
      m_done = 0;
      m_ovf = 0;
      return;
    end
    sz0 = mq.size();
    m_done = 0;
    if (m_in) begin
      m_t++;
      if (m_t == FRAME) begin
        m_done = 1;
        m_in = 0;
      end
    end
    if (!m_in && sz0 > 0) begin
      m_byte = mq.pop_front();
      m_in = 1;
      m_t = 0;
    end
    if (w) begin
      if (sz0 == DEPTH) m_ovf = 1;
      else mq.push_back(d);
    end
  endtask

  task automatic tick(input bit r, input bit w, input logic [7:0] d);
    rst = r;
    we = w;
    wdata = d;
    @(posedge clk);
    model_edge(r, w, d);
    @(negedge clk);
    rst = 1'b0;
    we = 1'b0;
    chk("txd", 32'(txd), 32'(m_txd()));
    chk("count", 32'(count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("busy", 32'(busy), 32'(m_in || mq.size() > 0));
    chk("byte_done", 32'(byte_done), 32'(m_done));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((m_in || mq.size() > 0) && n < limit) begin
      tick(0, 0, 8'h00);
      n++;
    end
    chk("drain_timeout", 32'(m_in || mq.size() > 0), 32'd0);
  endtask

  task automatic wait_slot(input int t, input int limit, input string tag);
    int n = 0;
    while (!(m_in && m_t == t) && n < limit) begin
      tick(0, 0, 8'h00);
      n++;
    end
    chk(tag, 32'(m_in && m_t == t), 32'd1);
  endtask

  initial begin
    int p;
    int dones;

    for (int i = 0; i < 3; i++) tick(1, 0, 8'h00);
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 100; i++) tick(0, 0, 8'h00);

    // single 0xAA frame
    tick(0, 1, 8'hAA);
    chk("aa_cnt", 32'(count), 32'd1);
    tick(0, 0, 8'h00);
    chk("aa_start", 32'(txd), 32'd0);
    for (int i = 0; i < FRAME - 1; i++) tick(0, 0, 8'h00);
    chk("aa_pre_done", 32'(byte_done), 32'd0);
    tick(0, 0, 8'h00);
    chk("aa_done", 32'(byte_done), 32'd1);
    chk("aa_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 20; i++) tick(0, 0, 8'h00);

    // three contiguous frames
    tick(0, 1, 8'h01);
    tick(0, 1, 8'h02);
    tick(0, 1, 8'h03);
    dones = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick(0, 0, 8'h00);
      if (byte_done) dones++;
    end
    chk("three_dones", 32'(dones), 32'd3);
    chk("three_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 10; i++) tick(0, 0, 8'h00);

    // overflow: 18 writes from idle
    for (int i = 1; i <= 18; i++) begin
      tick(0, 1, 8'(i));
      if (i == 17) begin
        chk("ovf_full17", 32'(full), 32'd1);
        chk("ovf_cnt17", 32'(count), 32'd16);
      end
    end
    chk("ovf_flag", 32'(overflow), 32'd1);
    drain(2000);

    // write lands on the STOP terminal edge while one byte waits
    tick(1, 0, 8'h00);
    tick(0, 1, 8'h3C);
    tick(0, 1, 8'hC3);
    wait_slot(FRAME - 1, 200, "simul_wait");
    tick(0, 1, 8'h99);
    chk("simul_cnt", 32'(count), 32'd1);
    chk("simul_full", 32'(full), 32'd0);
    chk("simul_start", 32'(txd), 32'd0);
    chk("simul_done", 32'(byte_done), 32'd1);
    drain(1000);

    // reset in the middle of data bit 3 of 0x5A
    tick(0, 1, 8'h5A);
    for (int i = 0; i < 4; i++) tick(0, 1, 8'(8'h10 + i));
    wait_slot(4 * BC + 4, 200, "mid_wait");
    tick(1, 0, 8'h00);
    chk("mid_txd", 32'(txd), 32'd1);
    chk("mid_cnt", 32'(count), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(byte_done), 32'd0);
    for (int i = 0; i < 5; i++) tick(0, 0, 8'h00);
    tick(0, 1, 8'h33);
    drain(500);

    // random traffic with varying write density
    p = 20;
    for (int i = 0; i < 6000; i++) begin
      if (i % 600 == 0) begin
        case ($urandom_range(0, 2))
          0: p = 2;
          1: p = 20;
          default: p = 90;
        endcase
      end
      tick($urandom_range(0, 2999) == 0,
           $urandom_range(0, 99) < p,
           8'($urandom));
    end
    drain(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
